mdu_seq: RTL and testbench

- Parametrised multiply/divide unit for the pipelined core's EX stage; it sits beside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU over a configurable number of cycles and holds results in HI/LO registers.
- Also services MTHI/MTLO writes.
- Exposes busy so hazard logic can stall later MDU instructions and MFHI/MFLO reads.

---
 rtl/mdu_seq_if.sv | 17 +
 rtl/mdu_seq.sv | 157 +++++++++++++++
 tb/tb_mdu_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       MDUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, MDUOp, A, B, cancel, input busy, done, HI, LO);
  modport slave  (input start, MDUOp, A, B, cancel, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Operands are captured at accept; the result is committed only after the fixed latency.
module mdu_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_seq_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_signed;
  logic             r_is_div;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_accept;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;

  logic [PW-1:0]    w_ma;
  logic [PW-1:0]    w_mb;
  logic [PW-1:0]    w_prod;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_ua;
  logic [WIDTH-1:0] w_ub;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; cancel wins over the final-cycle commit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (bus.cancel || (r_cnt == CW'(1))) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control strobes; any start outside IDLE is dropped
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_accept = 1'b0;
    w_commit = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    w_is_mul = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
    w_is_div = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
    if (r_state == S_IDLE && bus.start && !bus.cancel) begin
      w_accept = w_is_mul || w_is_div;
      w_mthi   = (bus.MDUOp == OP_MTHI);
      w_mtlo   = (bus.MDUOp == OP_MTLO);
    end
    if (r_state == S_RUN && !bus.cancel && r_cnt == CW'(1)) w_commit = 1'b1;
  end

  // Arithmetic on captured operands; one multiplier and one divider serve both signednesses
  always_comb begin
    w_ma     = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_mb     = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod   = w_ma * w_mb;
    w_a_neg  = r_signed & r_a[WIDTH-1];
    w_b_neg  = r_signed & r_b[WIDTH-1];
    w_ua     = w_a_neg ? (-r_a) : r_a;
    w_ub     = w_b_neg ? (-r_b) : r_b;
    w_dvs    = (r_b == '0) ? WIDTH'(1) : w_ub;
    w_uq     = w_ua / w_dvs;
    w_ur     = w_ua % w_dvs;
    w_hi_res = w_prod[PW-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b == '0) begin
        w_hi_res = r_a;
        w_lo_res = '1;
      end else begin
        // Most-negative / -1 wraps through negation to LO=A, HI=0
        w_hi_res = w_a_neg ? (-w_ur) : w_ur;
        w_lo_res = (w_a_neg ^ w_b_neg) ? (-w_uq) : w_uq;
      end
    end
  end

  // Counter, operand capture and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= w_commit;
      if (w_accept) begin
        r_cnt    <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_signed <= ~bus.MDUOp[0];
        r_is_div <= bus.MDUOp[1];
        r_a      <= bus.A;
        r_b      <= bus.B;
      end else if (r_state == S_RUN) begin
        r_cnt <= bus.cancel ? '0 : (r_cnt - CW'(1));
      end
      if (w_commit) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else begin
        if (w_mthi) r_hi <= bus.A;
        if (w_mtlo) r_lo <= bus.A;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, arithmetic corner cases, MT writes, cancel and reset.
module tb_mdu_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MDU op (possibly in a done cycle); optionally try an MTLO mid-flight.
  // Leaves the bench in the done cycle so the next op exercises back-to-back issue.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input bit intrude);
    int cnt;
    bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    tick();
    bus.start = 1'b0;
    chk({tag, "_done_lo"}, 64'(bus.done), 64'd0);
    chk({tag, "_old_hi"},  64'(bus.HI), 64'(m_hi));
    chk({tag, "_old_lo"},  64'(bus.LO), 64'(m_lo));
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      if (intrude && cnt == 2) begin
        bus.start = 1'b1; bus.MDUOp = 3'd5; bus.A = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    chk({tag, "_busy_len"}, 64'(cnt), 64'(n));
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_hi"}, 64'(bus.HI), 64'(e_hi));
    chk({tag, "_lo"}, 64'(bus.LO), 64'(e_lo));
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = '0;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_hi = '0; m_lo = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.MDUOp = '0; bus.A = '0; bus.B = '0; bus.cancel = 1'b0;
    #12;
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Reset mid-RUN clears everything without a clock edge
    mt(3'd4, 32'hCAFE_0001);
    mt(3'd5, 32'hCAFE_0002);
    chk("pre_hi", 64'(bus.HI), 64'h0000_0000_CAFE_0001);
    chk("pre_lo", 64'(bus.LO), 64'h0000_0000_CAFE_0002);
    bus.start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'hFFFF_FFFF; bus.B = 32'd2;
    tick();
    bus.start = 1'b0;
    tick();
    chk("midrun_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_hi", 64'(bus.HI), 64'd0);
    chk("arst_lo", 64'(bus.LO), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    m_hi = '0; m_lo = '0;

    // Arithmetic, chained back-to-back through done cycles
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult",  3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0", 3'd3, 32'h0000_0007, 32'h0000_0000, 10, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
    run_op("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("mtlo_busy", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);
    tick();
    chk("done_once", 64'(bus.done), 64'd0);

    // MTHI while idle
    mt(3'd4, 32'h1234_5678);
    chk("mthi_hi", 64'(bus.HI), 64'h0000_0000_1234_5678);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("mthi_done", 64'(bus.done), 64'd0);

    // Cancel at busy cycle 3
    mt(3'd4, 32'hAAAA_AAAA);
    mt(3'd5, 32'h5555_5555);
    bus.start = 1'b1; bus.MDUOp = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("c3_busy_before", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("c3_busy", 64'(bus.busy), 64'd0);
    chk("c3_done", 64'(bus.done), 64'd0);
    tick();
    chk("c3_done2", 64'(bus.done), 64'd0);
    chk("c3_hi", 64'(bus.HI), 64'h0000_0000_AAAA_AAAA);
    chk("c3_lo", 64'(bus.LO), 64'h0000_0000_5555_5555);

    // Cancel on the final RUN cycle
    bus.start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'd9; bus.B = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("cf_busy_before", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cf_busy", 64'(bus.busy), 64'd0);
    chk("cf_done", 64'(bus.done), 64'd0);
    chk("cf_hi", 64'(bus.HI), 64'h0000_0000_AAAA_AAAA);
    chk("cf_lo", 64'(bus.LO), 64'h0000_0000_5555_5555);
    tick();
    chk("cf_done2", 64'(bus.done), 64'd0);

    // Start with cancel while idle is suppressed
    bus.cancel = 1'b1;
    bus.start = 1'b1; bus.MDUOp = 3'd4; bus.A = 32'h1111_1111;
    tick();
    chk("sc_mthi", 64'(bus.HI), 64'h0000_0000_AAAA_AAAA);
    bus.MDUOp = 3'd2; bus.A = 32'd50; bus.B = 32'd5;
    tick();
    chk("sc_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.cancel = 1'b0;
    tick();
    chk("sc_done", 64'(bus.done), 64'd0);
    chk("sc_lo", 64'(bus.LO), 64'h0000_0000_5555_5555);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
